// File: rtl/pito_pkg.sv
// -----------------------------------------------------------------------------
// pito_pkg
// Shared types and header layout for the pito program loader.
//   loader_op_e  : command opcode carried in header bits [31:30]
//   loader_err_e : value reported on the loader's err_code output
//   HDR_*        : header bit-field positions
//   hdr_op/cnt   : header field extraction helpers
// -----------------------------------------------------------------------------
package pito_pkg;

    typedef enum logic [1:0] {
        LD_IMEM = 2'b00,
        LD_DMEM = 2'b01,
        START   = 2'b10,
        ILLEGAL = 2'b11
    } loader_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_FORMAT  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } loader_err_e;

    localparam int HDR_OP_HI  = 31;
    localparam int HDR_OP_LO  = 30;
    localparam int HDR_CNT_HI = 15;
    localparam int HDR_CNT_LO = 0;
    localparam int HDR_CNT_W  = HDR_CNT_HI - HDR_CNT_LO + 1;

    function automatic loader_op_e hdr_op(input logic [31:0] w);
        return loader_op_e'(w[HDR_OP_HI:HDR_OP_LO]);
    endfunction

    function automatic logic [HDR_CNT_W-1:0] hdr_cnt(input logic [31:0] w);
        return w[HDR_CNT_HI:HDR_CNT_LO];
    endfunction

endpackage

// File: rtl/pito_loader_wdog.sv
// -----------------------------------------------------------------------------
// pito_loader_wdog
// Loadable down-counter used as the RUN-phase watchdog.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val into the counter (has priority over en)
//   load_val   : start value; 0 keeps the counter idle, i.e. never expires
//   en         : count down one step this cycle (saturates at 0)
//   expired    : high while the counter sits on its final step
// -----------------------------------------------------------------------------
module pito_loader_wdog #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments on all state so every register samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Loaded with T, the counter reads 1 on the T-th enabled cycle.
    assign expired = (cnt == W'(1));

endmodule

// File: rtl/pito_prog_loader.sv
// -----------------------------------------------------------------------------
// pito_prog_loader
// Command-stream loader in front of pito_soc: writes program images into
// instruction/data memory, then runs the core under a watchdog.
//   clk, rst_n        : clock, synchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready    : 32-bit command stream (valid/ready)
//   wr_en/wr_dmem/
//   wr_addr/wr_data   : registered memory write port (0 = imem, 1 = dmem)
//   core_rst_n        : core reset, released only while running
//   core_done         : core finished (level, only looked at while running)
//   busy              : loader not idle
//   done              : one-cycle pulse when a run ends on core_done
//   err/err_code      : sticky error flag and cause (pito_pkg::loader_err_e)
// -----------------------------------------------------------------------------
module pito_prog_loader
    import pito_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IMEM_DEPTH  = 4096,
    parameter int DMEM_DEPTH  = 4096,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int AW = $clog2((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_en,
    output logic              wr_dmem,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_rst_n,
    input  logic              core_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W:0] IMEM_LIM = (DATA_W + 1)'(IMEM_DEPTH);
    localparam logic [DATA_W:0] DMEM_LIM = (DATA_W + 1)'(DMEM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_RUN, S_ERR} state_e;

    state_e                 state, state_n;
    logic                   dmem_sel;   // target of the load in progress
    logic [HDR_CNT_W-1:0]   rem;        // words still expected in DATA/DRAIN
    logic [AW-1:0]          cur_addr;   // address of the next DATA word
    logic                   accept;
    loader_op_e             op;
    logic [DATA_W:0]        end_addr;
    logic                   range_bad;
    logic                   wd_expired;

    logic        ld_hdr, ld_addr, wr_go, cnt_dec, run_go, fin_ok, err_set, err_clr;
    loader_err_e err_code_n;

    assign accept = s_valid & s_ready;
    assign op     = hdr_op(s_data[31:0]);

    // One bit wider than the stream, so base + N cannot wrap past the limit.
    assign end_addr  = {1'b0, s_data} + (DATA_W + 1)'(rem);
    assign range_bad = end_addr > (dmem_sel ? DMEM_LIM : IMEM_LIM);

    assign busy       = (state != S_IDLE);
    assign core_rst_n = (state == S_RUN);

    pito_loader_wdog #(.W(WD_W)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (run_go),
        .load_val (WD_W'(TIMEOUT_CYC)),
        .en       (state == S_RUN),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        state_n    = state;
        ld_hdr     = 1'b0;
        ld_addr    = 1'b0;
        wr_go      = 1'b0;
        cnt_dec    = 1'b0;
        run_go     = 1'b0;
        fin_ok     = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        err_code_n = ERR_NONE;
        unique case (state)
            S_IDLE: if (accept) begin
                err_clr = 1'b1;
                unique case (op)
                    LD_IMEM, LD_DMEM: begin
                        ld_hdr = 1'b1;
                        if (s_last) begin
                            state_n = S_ERR; err_set = 1'b1; err_code_n = ERR_FORMAT;
                        end else begin
                            state_n = S_ADDR;
                        end
                    end
                    START: begin
                        state_n = S_RUN;
                        run_go  = 1'b1;
                    end
                    default: begin
                        state_n = S_ERR; err_set = 1'b1; err_code_n = ERR_FORMAT;
                    end
                endcase
            end
            S_ADDR: if (accept) begin
                if (s_last) begin
                    state_n = S_ERR; err_set = 1'b1; err_code_n = ERR_FORMAT;
                end else if (range_bad) begin
                    err_set    = 1'b1;
                    err_code_n = ERR_RANGE;
                    state_n    = (rem == '0) ? S_IDLE : S_DRAIN;
                end else begin
                    ld_addr = 1'b1;
                    state_n = (rem == '0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA, S_DRAIN: if (accept) begin
                // s_last is only legal on the final word; a missing one is tolerated.
                if (s_last && rem != HDR_CNT_W'(1)) begin
                    state_n = S_ERR; err_set = 1'b1; err_code_n = ERR_FORMAT;
                end else begin
                    wr_go   = (state == S_DATA);
                    cnt_dec = 1'b1;
                    if (rem == HDR_CNT_W'(1)) state_n = S_IDLE;
                end
            end
            S_RUN: begin
                // core_done is checked first so it wins a tie with the watchdog.
                if (core_done) begin
                    state_n = S_IDLE; fin_ok = 1'b1;
                end else if (wd_expired) begin
                    state_n = S_ERR; err_set = 1'b1; err_code_n = ERR_TIMEOUT;
                end
            end
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready  <= 1'b0;
            wr_en    <= 1'b0;
            wr_dmem  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            dmem_sel <= 1'b0;
            rem      <= '0;
            cur_addr <= '0;
        end else begin
            s_ready <= state_n inside {S_IDLE, S_ADDR, S_DATA, S_DRAIN};
            wr_en   <= wr_go;
            done    <= fin_ok;
            if (ld_hdr) begin
                dmem_sel <= (op == LD_DMEM);
                rem      <= hdr_cnt(s_data[31:0]);
            end
            if (cnt_dec) rem <= rem - HDR_CNT_W'(1);
            if (ld_addr) cur_addr <= s_data[AW-1:0];
            if (wr_go) begin
                wr_dmem  <= dmem_sel;
                wr_addr  <= cur_addr;
                wr_data  <= s_data;
                cur_addr <= cur_addr + AW'(1);
            end
            // A new header clears the flag unless that same header is itself an error.
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_code_n;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_pito_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_pito_prog_loader
// Transaction-level reference model of the loader: each command's expected
// memory writes go into a queue and its expected error outcome is derived
// from the command fields; one monitor compares every DUT write and run cycle.
// -----------------------------------------------------------------------------
module tb_pito_prog_loader;

    localparam int IMEM_D = 4096;
    localparam int DMEM_D = 1024;
    localparam int TO     = 100;
    localparam int AW     = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          wr_en, wr_dmem;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          core_rst_n;
    logic          core_done = 1'b0;
    logic          busy, done, err;
    logic [1:0]    err_code;

    pito_prog_loader #(
        .DATA_W(32), .IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .wr_en(wr_en), .wr_dmem(wr_dmem), .wr_addr(wr_addr),
        .wr_data(wr_data), .core_rst_n(core_rst_n), .core_done(core_done),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dmem;
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_seen = 0;
    int          run_hi = 0;
    int          done_cnt = 0;
    int unsigned last_addr = 0;
    bit          last_dmem = 0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must be the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen++;
            last_addr = 32'(wr_addr);
            last_dmem = wr_dmem;
            last_data = wr_data;
            check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_dmem", 64'(wr_dmem), 64'(e.dmem));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
        if (core_rst_n) begin
            run_hi++;
            check("run_s_ready_low", 64'(s_ready), 64'(0));
        end
        if (done) begin
            done_cnt++;
            check("done_core_rst_low", 64'(core_rst_n), 64'(0));
        end
    end

    // Drive one word and hold it until it transfers (bounded).
    task automatic send(input logic [31:0] d, input bit l, input int gap);
        int  n;
        bit  r;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        r = 1'b0;
        while (!r && n < 200) begin
            @(negedge clk); r = s_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!r) check("send_ready_wait", 64'(r), 64'(1));
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(posedge clk); #1; n++; end
        check("idle_reached", 64'(busy), 64'(0));
        @(posedge clk); #1;  // lets the final registered write appear
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    endfunction

    // Load command; trunc = index of a premature s_last, or -1.
    task automatic do_load(input bit dm, input int unsigned a, input int n, input int trunc,
                           input bit hdr_last, input bit addr_last, input int gap,
                           input logic [31:0] dbase);
        int unsigned depth;
        bit          range_bad;
        int          exp_code;
        logic [31:0] w;
        bit          lst;
        wr_t         e;
        depth     = dm ? DMEM_D : IMEM_D;
        range_bad = (longint'(a) + longint'(n)) > longint'(depth);
        exp_code  = 0;
        send({1'b0, dm, 14'($urandom), 16'(n)}, hdr_last, pick_gap(gap));
        if (hdr_last) begin
            exp_code = 2;
        end else begin
            send(a, addr_last, pick_gap(gap));
            if (addr_last) begin
                exp_code = 2;
            end else begin
                for (int i = 0; i < n; i++) begin
                    w   = (dbase == '0) ? $urandom : dbase + 32'(i);
                    lst = (i == trunc) || (i == n - 1 && $urandom_range(0, 1) == 1);
                    if (!range_bad && i != trunc) begin
                        e.dmem = dm; e.addr = a + 32'(i); e.data = w;
                        exp_q.push_back(e);
                    end
                    send(w, lst, pick_gap(gap));
                    if (i == trunc) break;
                end
                exp_code = (trunc >= 0 && n > 0) ? 2 : (range_bad ? 1 : 0);
            end
        end
        wait_idle();
        check("writes_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        check("err", 64'(err), 64'(exp_code != 0));
        check("err_code", 64'(err_code), 64'(exp_code));
    endtask

    // Start command; core_done rises d cycles into the run.
    task automatic do_start(input int d);
        bit exp_to;
        int exp_cyc;
        exp_to  = (d + 1) > TO;
        exp_cyc = exp_to ? TO : d + 1;
        send({2'b10, 30'($urandom)}, 1'($urandom_range(0, 1)), 0);
        run_hi   = 0;
        done_cnt = 0;
        for (int k = 0; k < 400 && busy; k++) begin
            core_done = (k >= d);
            @(posedge clk); #1;
        end
        core_done = 1'b0;
        check("run_ended", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check("run_cycles", 64'(run_hi), 64'(exp_cyc));
        check("done_pulses", 64'(done_cnt), 64'(!exp_to));
        check("run_err", 64'(err), 64'(exp_to));
        check("run_err_code", 64'(err_code), 64'(exp_to ? 3 : 0));
        check("core_rst_after", 64'(core_rst_n), 64'(0));
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({s_ready, wr_en, wr_dmem, wr_addr, wr_data, core_rst_n, busy, done, err, err_code});
    endfunction

    initial begin
        int          w0;
        int          kind;
        bit          dm;
        int unsigned depth;
        int unsigned a;
        int          n;
        int          tr;
        wr_t         e;

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", out_vec(), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: imem load of four words at 0x10.
        w0 = wr_seen;
        do_load(1'b0, 32'h10, 4, -1, 1'b0, 1'b0, 0, 32'hD000_0000);
        check("t1_writes", 64'(wr_seen - w0), 64'(4));
        check("t1_last_addr", 64'(last_addr), 64'h13);
        check("t1_last_data", 64'(last_data), 64'hD000_0003);
        check("t1_imem", 64'(last_dmem), 64'(0));

        // 2: dmem load with s_valid dropping every other cycle.
        w0 = wr_seen;
        do_load(1'b1, 32'h10, 4, -1, 1'b0, 1'b0, 1, 32'hD100_0000);
        check("t2_writes", 64'(wr_seen - w0), 64'(4));
        check("t2_dmem", 64'(last_dmem), 64'(1));
        check("t2_last_data", 64'(last_data), 64'hD100_0003);

        // 3: range error drains the payload.
        w0 = wr_seen;
        do_load(1'b0, 32'hFFE, 4, -1, 1'b0, 1'b0, 0, 32'h0);
        check("t3_writes", 64'(wr_seen - w0), 64'(0));
        check("t3_err_code", 64'(err_code), 64'(1));

        // Exact fit at the top of dmem, and an empty load.
        w0 = wr_seen;
        do_load(1'b1, DMEM_D - 4, 4, -1, 1'b0, 1'b0, 0, 32'hE000_0000);
        check("fit_last_addr", 64'(last_addr), 64'(DMEM_D - 1));
        do_load(1'b0, 32'h0, 0, -1, 1'b0, 1'b0, 0, 32'h0);
        check("empty_writes", 64'(wr_seen - w0), 64'(4));

        // 4/5: run ending on core_done, tie at the timeout, and a real timeout.
        do_start(49);
        check("t4_cycles", 64'(run_hi), 64'(50));
        do_start(TO - 1);
        do_start(200);
        check("t5_cycles", 64'(run_hi), 64'(100));
        check("t5_err_code", 64'(err_code), 64'(3));

        // 6: premature s_last on the second of four words.
        w0 = wr_seen;
        do_load(1'b0, 32'h20, 4, 1, 1'b0, 1'b0, 0, 32'hF000_0000);
        check("t6_writes", 64'(wr_seen - w0), 64'(1));
        check("t6_err_code", 64'(err_code), 64'(2));

        // 6b: reset in the middle of a DATA burst.
        send({2'b00, 14'h0, 16'd4}, 1'b0, 0);
        send(32'h40, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            e.dmem = 1'b0; e.addr = 32'h40 + 32'(i); e.data = 32'hA500_0000 + 32'(i);
            exp_q.push_back(e);
            send(e.data, 1'b0, 0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_values", out_vec(), 64'(0));
        check("mid_reset_writes", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized command mix.
        for (int t = 0; t < 40; t++) begin
            kind  = int'($urandom_range(0, 9));
            dm    = 1'($urandom_range(0, 1));
            depth = dm ? DMEM_D : IMEM_D;
            case (kind)
                0, 1, 2, 3: begin
                    n = int'($urandom_range(0, 6));
                    a = $urandom_range(0, depth - 32'(n));
                    do_load(dm, a, n, -1, 1'b0, 1'b0, -1, 32'h0);
                end
                4: begin
                    n  = int'($urandom_range(0, 5));
                    a  = (t % 3 == 0) ? 32'hFFFF_FFF0 : depth - 32'(n) + 1 + $urandom_range(0, 3);
                    tr = (n >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
                    do_load(dm, a, n, tr, 1'b0, 1'b0, -1, 32'h0);
                end
                5: begin
                    n  = int'($urandom_range(2, 6));
                    a  = $urandom_range(0, depth - 32'(n));
                    tr = int'($urandom_range(0, n - 2));
                    do_load(dm, a, n, tr, 1'b0, 1'b0, -1, 32'h0);
                end
                6: begin
                    tr = int'($urandom_range(0, 1));
                    do_load(dm, 32'h8, 3, -1, tr == 1, tr == 0, -1, 32'h0);
                end
                7: begin
                    send({2'b11, 30'($urandom)}, 1'($urandom_range(0, 1)), 0);
                    wait_idle();
                    check("illegal_err", 64'(err), 64'(1));
                    check("illegal_code", 64'(err_code), 64'(2));
                end
                default: do_start(int'($urandom_range(0, 130)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
